// File: rtl/tanh_table_reader_pkg.sv
// tanh_reader_pkg: shared state encoding, default widths and fixed-point constants
// for the tanh table reader.
package tanh_reader_pkg;
   localparam int TR_DATA_WIDTH = 32;
   localparam int TR_FRAC_BITS  = 16;
   localparam int TR_ADDR_WIDTH = 8;
   localparam int TR_STEP_SHIFT = 4;
   localparam int WEIGHT_SHIFT  = TR_FRAC_BITS - TR_STEP_SHIFT;
   localparam logic [TR_DATA_WIDTH-1:0] ONE_Q = TR_DATA_WIDTH'(1) << TR_FRAC_BITS;
   typedef enum logic [2:0] {IDLE, RD_BASE, RD_NEXT, CAPTURE, CALC, OUT} state_t;
endpackage

// File: rtl/tanh_table_reader_if.sv
// tanh_table_reader_if: input, table-memory and result handshake signals of the reader;
// master is the reader, slave is its environment.
interface tanh_table_reader_if
   import tanh_reader_pkg::*;
#(
   parameter int DATA_WIDTH = TR_DATA_WIDTH,
   parameter int ADDR_WIDTH = TR_ADDR_WIDTH
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] x_value;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   modport master (
      input  in_valid, x_value, mem_rd_data, out_ready,
      output in_ready, mem_rd_en, mem_addr, out_valid, out_data
   );
   modport slave (
      output in_valid, x_value, mem_rd_data, out_ready,
      input  in_ready, mem_rd_en, mem_addr, out_valid, out_data
   );
endinterface

// File: rtl/tanh_table_reader_lerp_unit.sv
// tanh_lerp_unit: linear interpolation between two table samples with an unsigned
// weight, floor on the weight shift, then conditional negation for odd symmetry.
module tanh_lerp_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int WEIGHT_SHIFT = 12
) (
   input  logic [DATA_WIDTH-1:0]   base,
   input  logic [DATA_WIDTH-1:0]   nxt,
   input  logic [WEIGHT_SHIFT-1:0] frac,
   input  logic                    sign,
   output logic [DATA_WIDTH-1:0]   y
);
   logic signed [DATA_WIDTH:0]                diff;
   logic signed [DATA_WIDTH+WEIGHT_SHIFT+1:0] prod;
   logic [DATA_WIDTH-1:0]                     r;
   assign diff = $signed({nxt[DATA_WIDTH-1], nxt}) - $signed({base[DATA_WIDTH-1], base});
   assign prod = diff * $signed({1'b0, frac});
   assign r    = base + DATA_WIDTH'(prod >>> WEIGHT_SHIFT);
   assign y    = sign ? -r : r;
endmodule

// File: rtl/tanh_table_reader.sv
// tanh_table_reader: reads two neighbouring tanh samples per x, interpolates and mirrors
// for negative x. Define TANH_READER_REUSE_EN to keep a one-entry sample-pair cache.
module tanh_table_reader
   import tanh_reader_pkg::*;
#(
   parameter int DATA_WIDTH = TR_DATA_WIDTH,
   parameter int FRAC_BITS  = TR_FRAC_BITS,
   parameter int ADDR_WIDTH = TR_ADDR_WIDTH,
   parameter int STEP_SHIFT = TR_STEP_SHIFT
) (
   input logic clk,
   input logic rst_n,
   tanh_table_reader_if.master bus
);
   localparam int W = FRAC_BITS - STEP_SHIFT;
   localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1) << FRAC_BITS;
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] IDX_SAT  = DATA_WIDTH'((2**ADDR_WIDTH) - 1);

   state_t                state_q, state_d;
   logic                  in_ready_q, in_ready_d;
   logic                  mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  sign_q, sign_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [W-1:0]          frac_q, frac_d;
   logic [DATA_WIDTH-1:0] base_q, base_d;
   logic [DATA_WIDTH-1:0] next_q, next_d;
`ifdef TANH_READER_REUSE_EN
   logic                  c_vld_q, c_vld_d;
   logic [ADDR_WIDTH-1:0] c_idx_q, c_idx_d;
   logic [DATA_WIDTH-1:0] c_base_q, c_base_d;
   logic [DATA_WIDTH-1:0] c_next_q, c_next_d;
`endif

   logic [DATA_WIDTH-1:0] mag, idx_full, lerp_y;
   logic                  accept, sat;

   assign accept   = bus.in_valid & in_ready_q;
   assign mag      = bus.x_value[DATA_WIDTH-1] ? -bus.x_value : bus.x_value;
   assign idx_full = mag >> W;
   // idx+1 must stay inside the table, and |most-negative| does not fit
   assign sat      = (idx_full >= IDX_SAT) || (bus.x_value == MOST_NEG);

   tanh_lerp_unit #(.DATA_WIDTH(DATA_WIDTH), .WEIGHT_SHIFT(W)) u_lerp (
      .base(base_q), .nxt(next_q), .frac(frac_q), .sign(sign_q), .y(lerp_y)
   );

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      mem_rd_en_d = mem_rd_en_q;
      mem_addr_d  = mem_addr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sign_d      = sign_q;
      idx_d       = idx_q;
      frac_d      = frac_q;
      base_d      = base_q;
      next_d      = next_q;
`ifdef TANH_READER_REUSE_EN
      c_vld_d     = c_vld_q;
      c_idx_d     = c_idx_q;
      c_base_d    = c_base_q;
      c_next_d    = c_next_q;
`endif
      unique case (state_q)
         IDLE: begin
            in_ready_d = ~accept;
            if (accept) begin
               sign_d = bus.x_value[DATA_WIDTH-1];
               idx_d  = idx_full[ADDR_WIDTH-1:0];
               frac_d = mag[W-1:0];
               if (sat) begin
                  base_d  = ONE;
                  next_d  = ONE;
                  state_d = CALC;
               end
`ifdef TANH_READER_REUSE_EN
               else if (c_vld_q && c_idx_q == idx_full[ADDR_WIDTH-1:0]) begin
                  base_d  = c_base_q;
                  next_d  = c_next_q;
                  state_d = CALC;
               end
`endif
               else begin
                  mem_rd_en_d = 1'b1;
                  mem_addr_d  = idx_full[ADDR_WIDTH-1:0];
                  state_d     = RD_BASE;
               end
            end
         end
         RD_BASE: begin
            mem_addr_d = idx_q + 1'b1;
            state_d    = RD_NEXT;
         end
         // read data trails its strobe by one cycle, so base lands here and next in CAPTURE
         RD_NEXT: begin
            mem_rd_en_d = 1'b0;
            base_d      = bus.mem_rd_data;
            state_d     = CAPTURE;
         end
         CAPTURE: begin
            next_d  = bus.mem_rd_data;
            state_d = CALC;
`ifdef TANH_READER_REUSE_EN
            c_vld_d  = 1'b1;
            c_idx_d  = idx_q;
            c_base_d = base_q;
            c_next_d = bus.mem_rd_data;
`endif
         end
         CALC: begin
            out_data_d  = lerp_y;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sign_q      <= 1'b0;
         idx_q       <= '0;
         frac_q      <= '0;
         base_q      <= '0;
         next_q      <= '0;
`ifdef TANH_READER_REUSE_EN
         c_vld_q     <= 1'b0;
         c_idx_q     <= '0;
         c_base_q    <= '0;
         c_next_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         mem_rd_en_q <= mem_rd_en_d;
         mem_addr_q  <= mem_addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sign_q      <= sign_d;
         idx_q       <= idx_d;
         frac_q      <= frac_d;
         base_q      <= base_d;
         next_q      <= next_d;
`ifdef TANH_READER_REUSE_EN
         c_vld_q     <= c_vld_d;
         c_idx_q     <= c_idx_d;
         c_base_q    <= c_base_d;
         c_next_q    <= c_next_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_rd_en = mem_rd_en_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_tanh_table_reader.sv
// tb_tanh_table_reader: directed vectors against literal expectations plus a scoreboard
// fed by an arithmetic tanh-interpolation model and a registered table memory.
module tb_tanh_table_reader;
   import tanh_reader_pkg::*;
`ifdef TANH_READER_REUSE_EN
   localparam int HIT_LAT = 1;
   localparam int BB_RDS  = 2;
`else
   localparam int HIT_LAT = 4;
   localparam int BB_RDS  = 4;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   tests = 0;
   int   errors = 0;
   int   rd_cycles = 0;
   logic [31:0] tbl [256];
   logic [7:0]  addr_log [$];
   logic [31:0] exp_q [$];

   tanh_table_reader_if bus ();
   tanh_table_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] x);
      longint mag, idx, frac, b, n, r;
      mag  = x[31] ? -longint'($signed(x)) : longint'(x);
      idx  = mag >> 12;
      frac = mag & 64'hFFF;
      if (idx >= 255) r = 65536;
      else begin
         b = longint'($signed(tbl[idx]));
         n = longint'($signed(tbl[idx+1]));
         r = b + (((n - b) * frac) >>> 12);
      end
      return 32'(x[31] ? -r : r);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rd_data <= tbl[bus.mem_addr];
         rd_cycles++;
         addr_log.push_back(bus.mem_addr);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_q.delete();
      else begin
         if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.x_value));
         if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL spurious_out_valid: got out_data %h with nothing outstanding", bus.out_data);
         end else chk("scoreboard", bus.out_data, exp_q[0]);
      end
   end

   task automatic txn(input logic [31:0] x, input logic [31:0] exp, input int lat, input int hold);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_value  = x;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", n < 50, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("latency", n, lat);
      chk("model_pin", model(x), exp);
      chk("out_data", bus.out_data, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1 chk("hold_valid", bus.out_valid, 1);
         chk("hold_data", bus.out_data, exp);
         chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk("post_hs_valid", bus.out_valid, 0);
      chk("post_hs_in_ready", bus.in_ready, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
      chk({tag, "_addr"}, bus.mem_addr, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_data"}, bus.out_data, 0);
   endtask

   initial begin
      int rd0;
      for (int i = 0; i < 256; i++) tbl[i] = 32'(i * 32'h1000);
      tbl[4]  = 32'h5000;
      tbl[10] = 32'h8000;
      tbl[11] = 32'h7FFF;
      bus.in_valid    = 1'b0;
      bus.x_value     = '0;
      bus.out_ready   = 1'b0;
      bus.mem_rd_data = '0;
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("idle_in_ready", bus.in_ready, 1);

      addr_log.delete();
      txn(32'h0000_1800, 32'h0000_1800, 4, 0);
      chk("addr_count", addr_log.size(), 2);
      if (addr_log.size() == 2) begin
         chk("addr_base", addr_log[0], 1);
         chk("addr_next", addr_log[1], 2);
      end
      txn(32'h0000_3800, 32'h0000_4000, 4, 0);
      rd0 = rd_cycles;
      txn(32'h0010_0000, 32'h0001_0000, 1, 3);
      chk("sat_no_reads", rd_cycles - rd0, 0);
      txn(32'hFFFF_C800, 32'hFFFF_C000, HIT_LAT, 0);
      txn(32'h8000_0000, 32'hFFFF_0000, 1, 0);
      txn(32'h000F_E800, 32'h000F_E800, 4, 0);
      txn(32'h000F_F000, 32'h0001_0000, 1, 0);
      txn(32'h0000_A001, 32'h0000_7FFF, 4, 0);

      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_value  = 32'h0000_1800;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      #1 chk("rd_next_rd_en", bus.mem_rd_en, 1);
      chk("rd_next_addr", bus.mem_addr, 2);
      #1 rst_n = 1'b0;
      #1 chk_reset("async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      txn(32'h0000_3800, 32'h0000_4000, 4, 0);

      rd0 = rd_cycles;
      txn(32'h0000_1800, 32'h0000_1800, 4, 0);
      txn(32'h0000_1800, 32'h0000_1800, HIT_LAT, 0);
      chk("b2b_reads", rd_cycles - rd0, BB_RDS);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end
endmodule
